// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: captures a packed BCD word, decodes one digit per
// refresh slot with optional leading-zero blanking, and flags non-decimal nibbles.
module bcd_display_scanner #(
  parameter int N_DIGITS    = 3,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [4*N_DIGITS-1:0] i_bcd,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_an,
  output logic                  o_err
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_OFF = {7{POL}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{POL}};

  logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
  logic                  blank_lz_q, blank_lz_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  err_q, err_d;

  logic [N_DIGITS-1:0] nib_zero;
  logic [N_DIGITS-1:0] nib_bad;
  logic [N_DIGITS-1:0] blank_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are zero.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign nib_zero[gi] = (bcd_q[4*gi +: 4] == 4'd0);
    assign nib_bad[gi]  = (bcd_q[4*gi +: 4] > 4'd9);
    if (gi == 0) begin : g_lsd
      assign blank_digit[gi] = 1'b0;
    end else begin : g_upper
      assign blank_digit[gi] = blank_lz_q & (&nib_zero[N_DIGITS-1:gi]);
    end
  end

  logic       tick;
  logic [3:0] cur_nib;
  logic       cur_blank;
  logic [N_DIGITS-1:0] an_raw;

  always_comb begin
    cur_nib   = bcd_q[3:0];
    cur_blank = 1'b0;
    an_raw    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = bcd_q[4*k +: 4];
        cur_blank = blank_digit[k];
        an_raw[k] = 1'b1;
      end
    end
  end

  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    bcd_d      = i_load ? i_bcd : bcd_q;
    blank_lz_d = i_load ? i_blank_lz : blank_lz_q;
    seg_d      = (cur_blank ? 7'h00 : seg_decode(cur_nib)) ^ SEG_OFF;
    an_d       = an_raw ^ AN_OFF;
    err_d      = |nib_bad;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bcd_q      <= '0;
      blank_lz_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
      err_q      <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      blank_lz_q <= blank_lz_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      err_q      <= err_d;
    end
  end

  assign o_seg = seg_q;
  assign o_an  = an_q;
  assign o_err = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations for an active-high and an
// active-low instance; a negedge monitor pops and compares them.
module tb_bcd_display_scanner;

  localparam int ND = 3;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst0, rst1, load, blz;
  logic [11:0] bcd;
  logic [6:0]  seg0, seg1;
  logic [2:0]  an0, an1;
  logic        err0, err1;

  always #5 clk = ~clk;

  bcd_display_scanner #(.N_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(0)) dut0 (
    .i_clock(clk), .i_reset(rst0), .i_bcd(bcd), .i_load(load), .i_blank_lz(blz),
    .o_seg(seg0), .o_an(an0), .o_err(err0)
  );

  bcd_display_scanner #(.N_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut1 (
    .i_clock(clk), .i_reset(rst1), .i_bcd(bcd), .i_load(load), .i_blank_lz(blz),
    .o_seg(seg1), .o_an(an1), .o_err(err1)
  );

  typedef struct {
    int         cyc;
    int         inst;
    string      tag;
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   base0 = 0;
  int   base1 = 0;
  bit   done = 1'b0;
  bit   done_chk = 1'b0;
  logic [6:0] pc0, pc1, pc2;
  logic       perr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] gs;
    logic [2:0] ga;
    logic       ge;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      gs = (e.inst == 0) ? seg0 : seg1;
      ga = (e.inst == 0) ? an0 : an1;
      ge = (e.inst == 0) ? err0 : err1;
      total++;
      if (e.cyc != cyc || gs !== e.seg || ga !== e.an || ge !== e.err) begin
        bad++;
        $display("FAIL %s cyc=%0d/%0d inst=%0d got seg=%h an=%b err=%b want seg=%h an=%b err=%b",
                 e.tag, cyc, e.cyc, e.inst, gs, ga, ge, e.seg, e.an, e.err);
      end else begin
        $display("ok   %s cyc=%0d inst=%0d seg=%h an=%b err=%b", e.tag, cyc, e.inst, gs, ga, ge);
      end
    end
    if (done && !done_chk) begin
      done_chk = 1'b1;
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL drain got %0d pending entries want 0", q.size());
      end
    end
  end

  task automatic push_one(input int inst, input int m, input logic [6:0] s, input logic [2:0] a,
                          input logic e, input string tag);
    logic [6:0] sv;
    logic [2:0] av;
    sv = (inst == 1) ? ~s : s;
    av = (inst == 1) ? ~a : a;
    q.push_back('{cyc: m, inst: inst, tag: tag, seg: sv, an: av, err: e});
  endtask

  // Digit shown at edge m is the index held before that edge: floor((m-base-1)/RD) mod ND.
  task automatic push_scan(input int inst, input int base, input int from, input int count,
                           input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                           input logic e, input string tag);
    int         d;
    logic [6:0] s;
    for (int m = from; m < from + count; m++) begin
      d = ((m - base - 1) / RD) % ND;
      s = (d == 0) ? c0 : (d == 1) ? c1 : c2;
      push_one(inst, m, s, 3'b001 << d, e, tag);
    end
  endtask

  task automatic push_both(input int from, input int count, input logic [6:0] c0,
                           input logic [6:0] c1, input logic [6:0] c2, input logic e,
                           input string tag);
    for (int m = from; m < from + count; m++) begin
      push_scan(0, base0, m, 1, c0, c1, c2, e, tag);
      push_scan(1, base0, m, 1, c0, c1, c2, e, tag);
    end
  endtask

  // phase = (load edge - base0) mod RD; phase 0 is a tick edge.
  task automatic show_word(input logic [11:0] w, input logic bz, input int phase,
                           input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                           input logic e, input string tag);
    int guard;
    guard = 0;
    while (((cyc + 1 - base0) % RD) != phase && guard < RD) begin
      @(posedge clk); #1;
      guard++;
    end
    bcd  = w;
    blz  = bz;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    push_both(cyc, 1, pc0, pc1, pc2, perr, {tag, "-old"});
    push_both(cyc + 1, ND * RD, c0, c1, c2, e, tag);
    pc0 = c0; pc1 = c1; pc2 = c2; perr = e;
    repeat (ND * RD) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int guard;
    rst0 = 1'b1; rst1 = 1'b1; load = 1'b0; blz = 1'b0; bcd = '0;
    @(posedge clk); #1;
    for (int m = 1; m <= 3; m++) begin
      push_one(0, m, 7'h00, 3'b000, 1'b0, "reset");
      push_one(1, m, 7'h00, 3'b000, 1'b0, "reset");
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst0 = 1'b0; rst1 = 1'b0;
    base0 = cyc;
    pc0 = 7'h3F; pc1 = 7'h3F; pc2 = 7'h3F; perr = 1'b0;
    push_both(base0 + 1, ND * RD, pc0, pc1, pc2, perr, "idle");
    repeat (ND * RD) begin
      @(posedge clk); #1;
    end

    show_word(12'h123, 1'b0, 1, 7'h4F, 7'h5B, 7'h06, 1'b0, "w123");
    show_word(12'h007, 1'b1, 2, 7'h07, 7'h00, 7'h00, 1'b0, "w007_lz");
    show_word(12'h000, 1'b1, 0, 7'h3F, 7'h00, 7'h00, 1'b0, "w000_lz_tick");
    show_word(12'h070, 1'b1, 3, 7'h3F, 7'h07, 7'h00, 1'b0, "w070_lz");
    show_word(12'h1A3, 1'b0, 0, 7'h4F, 7'h79, 7'h06, 1'b1, "w1A3_err_tick");
    show_word(12'h456, 1'b0, 2, 7'h7D, 7'h6D, 7'h66, 1'b0, "w456_clr");
    show_word(12'h0A0, 1'b1, 1, 7'h3F, 7'h79, 7'h00, 1'b1, "w0A0_lz_err");
    show_word(12'h900, 1'b1, 0, 7'h3F, 7'h3F, 7'h6F, 1'b0, "w900_lz");
    show_word(12'h808, 1'b1, 3, 7'h7F, 7'h3F, 7'h7F, 1'b0, "w808_lz");
    show_word(12'h1A3, 1'b1, 1, 7'h4F, 7'h79, 7'h06, 1'b1, "w1A3_lz_err");

    // Reset the active-low instance in the middle of digit 2's slot.
    guard = 0;
    while (((cyc - base0) % (ND * RD)) != 9 && guard < ND * RD) begin
      @(posedge clk); #1;
      guard++;
    end
    rst1 = 1'b1;
    for (int m = cyc + 1; m <= cyc + 3; m++) begin
      push_one(1, m, 7'h00, 3'b000, 1'b0, "al_reset");
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst1 = 1'b0;
    base1 = cyc;
    push_scan(1, base1, base1 + 1, ND * RD + 2, 7'h3F, 7'h3F, 7'h3F, 1'b0, "al_restart");
    repeat (ND * RD + 4) begin
      @(posedge clk); #1;
    end

    done = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
